// File: rtl/control_fsm.sv
// Multicycle main control unit: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables, ALU control and the completed-instruction counter.
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Opcode,
  input  logic        InstrValid,
  input  logic        MemReady,
  input  logic        zero,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        IllegalOp,
  output logic [2:0]  State,
  output logic [31:0] InstrCount
);

  // state  | meaning
  // FETCH  | wait for InstrValid, load IR and PC+4
  // DECODE | classify Opcode, latch it into op_q
  // EXEC   | drive ALU source/operation
  // MEM    | hold data memory strobe until MemReady
  // WB     | register-file write
  // BRANCH | beq compare, PC load on zero
  // JUMP   | PC load from jump target
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] cnt_q, cnt_d;

  logic       alu_src_c, pc_write_c, ir_write_c, mem_read_c, mem_write_c;
  logic       reg_write_c, reg_dst_c, mem_to_reg_c, illegal_c;
  logic [1:0] alu_op_c, pc_src_c;
  logic       op_is_imm;

  assign op_is_imm = (op_q == OP_ADDI) || (op_q == OP_ANDI) ||
                     (op_q == OP_ORI)  || (op_q == OP_SLTI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    alu_src_c    = 1'b0;
    alu_op_c     = 2'b00;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = InstrValid;
        pc_write_c = InstrValid;
        if (InstrValid) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC;
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        if (op_q == OP_R) begin
          alu_op_c = 2'b10;
        end else if (op_is_imm) begin
          alu_src_c = 1'b1;
          alu_op_c  = 2'b11;
        end else begin
          alu_src_c = 1'b1;
        end
        state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_read_c  = (op_q == OP_LW);
        mem_write_c = (op_q == OP_SW);
        if (MemReady) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (op_q == OP_R);
        mem_to_reg_c = (op_q == OP_LW);
        state_d      = S_FETCH;
        cnt_d        = cnt_q + 32'd1;
      end
      S_BRANCH: begin
        alu_op_c   = 2'b01;
        pc_src_c   = 2'b01;
        pc_write_c = zero;
        state_d    = S_FETCH;
        cnt_d      = cnt_q + 32'd1;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
        state_d    = S_FETCH;
        cnt_d      = cnt_q + 32'd1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Gating with rst_n keeps the Mealy terms (InstrValid, zero) quiet during reset.
  assign ALUSrc     = rst_n & alu_src_c;
  assign ALUOp      = rst_n ? alu_op_c : 2'b00;
  assign PCWrite    = rst_n & pc_write_c;
  assign PCSrc      = rst_n ? pc_src_c : 2'b00;
  assign IRWrite    = rst_n & ir_write_c;
  assign MemRead    = rst_n & mem_read_c;
  assign MemWrite   = rst_n & mem_write_c;
  assign RegWrite   = rst_n & reg_write_c;
  assign RegDst     = rst_n & reg_dst_c;
  assign MemtoReg   = rst_n & mem_to_reg_c;
  assign IllegalOp  = rst_n & illegal_c;
  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: a per-cycle expected-output queue built from
// an instruction-level model, checked by an independent negedge monitor.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic        InstrValid = 1'b0;
  logic        MemReady = 1'b0;
  logic        zero = 1'b0;
  logic        ALUSrc, PCWrite, IRWrite, MemRead, MemWrite;
  logic        RegWrite, RegDst, MemtoReg, IllegalOp;
  logic [1:0]  ALUOp, PCSrc;
  logic [2:0]  State;
  logic [31:0] InstrCount;

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .InstrValid(InstrValid),
    .MemReady(MemReady), .zero(zero), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .IllegalOp(IllegalOp), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        pcw;
    logic [1:0]  pcsrc;
    logic        irw;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        rd;
    logic        m2r;
    logic        ill;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_cyc = 0;
  logic [31:0] model_cnt = 0;

  function automatic bit is_legal(logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_imm(logic [5:0] op);
    return (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010);
  endfunction

  // Expected outputs for one cycle spent in phase ph while executing op.
  function automatic obs_t expect_obs(int ph, logic [5:0] op, logic valid, logic zv, logic [31:0] c);
    obs_t e;
    e = '0;
    e.st = 3'(ph);
    e.cnt = c;
    case (ph)
      0: begin e.irw = valid; e.pcw = valid; end
      1: e.ill = !is_legal(op);
      2: begin
        if (op == 6'b000000) e.aluop = 2'b10;
        else if (is_imm(op)) begin e.alusrc = 1'b1; e.aluop = 2'b11; end
        else e.alusrc = 1'b1;
      end
      3: begin e.mr = (op == 6'b100011); e.mw = (op == 6'b101011); end
      4: begin e.rw = 1'b1; e.rd = (op == 6'b000000); e.m2r = (op == 6'b100011); end
      5: begin e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcw = zv; end
      6: begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic v, input logic [5:0] opc,
                     input logic mr, input logic z, input obs_t e);
    @(posedge clk);
    #1;
    rst_n = rst;
    InstrValid = v;
    Opcode = opc;
    MemReady = mr;
    zero = z;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    model_cnt = 0;
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
          expect_obs(0, 6'd0, 1'b0, 1'b0, 32'd0));
  endtask

  // Runs one instruction; abort asserts reset asynchronously in the first MEM cycle.
  task automatic run_instr(input logic [5:0] op, input int w, input logic zv,
                           input int idle, input bit abort);
    int   ph[$];
    int   mem_k;
    logic v, mr, z;
    logic [5:0] opc;
    for (int i = 0; i < idle; i++)
      cyc(1'b1, 1'b0, 6'($urandom), 1'($urandom), 1'($urandom),
          expect_obs(0, op, 1'b0, 1'b0, model_cnt));
    ph = '{0, 1};
    if (is_legal(op)) begin
      if (op == 6'b000100) ph.push_back(5);
      else if (op == 6'b000010) ph.push_back(6);
      else begin
        ph.push_back(2);
        if (op == 6'b100011 || op == 6'b101011)
          for (int k = 0; k <= w; k++) ph.push_back(3);
        if (op != 6'b101011) ph.push_back(4);
      end
    end
    mem_k = 0;
    for (int i = 0; i < ph.size(); i++) begin
      v   = (ph[i] == 0) ? 1'b1 : 1'($urandom);
      opc = (ph[i] == 1) ? op : 6'($urandom);
      z   = (ph[i] == 5) ? zv : 1'($urandom);
      if (ph[i] == 3) begin
        mr = (mem_k == w);
        mem_k++;
      end else begin
        mr = 1'($urandom);
      end
      cyc(1'b1, v, opc, mr, z, expect_obs(ph[i], op, v, zv, model_cnt));
      if (abort && ph[i] == 3) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || State !== 3'd0 || InstrCount !== 32'd0) begin
          n_fail++;
          $display("FAIL async_reset_abort: got MemWrite=%b State=%0d InstrCount=%0d, required 0/0/0",
                   MemWrite, State, InstrCount);
        end
        reset_cycles(2);
        return;
      end
    end
    if (is_legal(op)) model_cnt = model_cnt + 32'd1;
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {State, ALUSrc, ALUOp, PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
             RegWrite, RegDst, MemtoReg, IllegalOp, InstrCount};
        n_checks++;
        n_cyc++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs #%0d: got st=%0d src=%b op=%b pcw=%b pcs=%b irw=%b mr=%b mw=%b rw=%b rd=%b m2r=%b ill=%b cnt=%0d, required st=%0d src=%b op=%b pcw=%b pcs=%b irw=%b mr=%b mw=%b rw=%b rd=%b m2r=%b ill=%b cnt=%0d",
                   n_cyc, a.st, a.alusrc, a.aluop, a.pcw, a.pcsrc, a.irw, a.mr, a.mw, a.rw, a.rd, a.m2r, a.ill, a.cnt,
                   e.st, e.alusrc, e.aluop, e.pcw, e.pcsrc, e.irw, e.mr, e.mw, e.rw, e.rd, e.m2r, e.ill, e.cnt);
        end
      end
    end
  end

  logic [5:0] legal_ops [9];
  initial begin : stimulus
    logic [5:0] op;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001010};
    InstrValid = 1'b1;
    reset_cycles(3);
    run_instr(6'b000000, 0, 1'b0, 0, 1'b0);
    run_instr(6'b100011, 2, 1'b0, 0, 1'b0);
    run_instr(6'b000100, 0, 1'b1, 0, 1'b0);
    run_instr(6'b000100, 0, 1'b0, 0, 1'b0);
    run_instr(6'b111111, 0, 1'b0, 0, 1'b0);
    run_instr(6'b101011, 0, 1'b0, 1, 1'b0);
    run_instr(6'b100011, 0, 1'b0, 0, 1'b0);
    run_instr(6'b101011, 3, 1'b0, 0, 1'b1);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op, int'($urandom_range(0, 3)), 1'($urandom),
                int'($urandom_range(0, 2)), ($urandom_range(0, 39) == 0));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main control unit for the processor datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the ALUSrc/ALUOp control pair consumed by the execute/ALU stage, along with PC, instruction-register, memory and register-file enables. It samples the ALU zero flag to resolve branches, and waits on instruction- and data-memory ready handshakes.

## Interface
- No parameters; opcode map and encodings fixed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- InstrValid  in  1  instruction memory word valid this cycle
- MemReady  in  1  data memory access complete this cycle
- zero  in  1  ALU zero flag from the execute stage (combinational, same cycle)
- ALUSrc  out  1  0 = register operand B, 1 = sign-extended immediate
- ALUOp  out  2  00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode)
- PCWrite  out  1  load PC this cycle
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- IRWrite  out  1  load instruction register
- MemRead, MemWrite  out  1 each  data memory strobes
- RegWrite, RegDst, MemtoReg  out  1 each  register-file write enable, rd(1)/rt(0), memory(1)/ALU(0) data
- IllegalOp  out  1  one-cycle pulse on an undefined opcode
- State  out  3  current state, for debug
- InstrCount  out  32  completed-instruction counter

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010. Every other opcode is illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, JUMP 6. Encoding 7 is unreachable and recovers to FETCH.
- FETCH
  - IRWrite=InstrValid, PCWrite=InstrValid, PCSrc=00.
  - Stays in FETCH while InstrValid=0; goes to DECODE when InstrValid=1.
- DECODE
  - Opcode is latched into an internal OpReg on exit. Later states use only OpReg.
  - R, I-arithmetic, lw and sw go to EXEC. beq goes to BRANCH. j goes to JUMP.
  - An illegal opcode pulses IllegalOp=1 and returns to FETCH.
- EXEC
  - R: ALUSrc=0, ALUOp=10.
  - I-arithmetic: ALUSrc=1, ALUOp=11.
  - lw/sw: ALUSrc=1, ALUOp=00.
  - Next state: MEM for lw/sw, otherwise WB.
- MEM
  - MemRead (lw) or MemWrite (sw) is held high until MemReady=1.
  - On MemReady, lw goes to WB and sw goes to FETCH.
- WB
  - RegWrite=1. RegDst=1 only for R. MemtoReg=1 only for lw.
  - Next state: FETCH.
- BRANCH
  - ALUSrc=0, ALUOp=01, PCSrc=01, PCWrite=zero (Mealy).
  - Next state: FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next state: FETCH.
- Default values: outputs not listed for a state are 0 in that state.
- InstrCount
  - +1 (mod 2^32, wraps silently) on every transition into FETCH from WB, BRANCH, JUMP, or MEM-for-sw.
  - Not incremented on the illegal-opcode return.

## Timing
- Reset
  - While rst_n=0, state is FETCH and InstrCount is 0.
  - Every output is forced to 0 during reset, including Mealy terms; State reads 0.
  - Reset asserted mid-instruction aborts it immediately: no further strobes, count unchanged from its reset value 0.
- Cycle counts, measured from the FETCH cycle with InstrValid=1 to the next FETCH:
  - beq, j: 3 cycles.
  - R, I-arithmetic: 4 cycles.
  - sw: 4 + w cycles; lw: 5 + w cycles, where w = MEM cycles with MemReady=0.
  - Illegal opcode: 2 cycles.
- MemReady already high on MEM entry: one MEM cycle, w=0.
- MemReady outside MEM is ignored. InstrValid outside FETCH is ignored.
- The branch decision uses zero in the BRANCH cycle only.
- All state and counter updates happen on the rising clk edge.

## Test plan
- Reset: hold rst_n=0 with InstrValid=1 → all outputs 0 and State=0; release → IRWrite=PCWrite=1 on the first cycle.
- R-type add: Opcode=000000, InstrValid=1 → State sequence 0,1,2,4,0; ALUOp=10 and ALUSrc=0 in EXEC; RegWrite=RegDst=1 in WB; InstrCount=1.
- lw with MemReady low for 2 cycles → MEM lasts 3 cycles with MemRead=1 throughout; WB has MemtoReg=1; total 7 cycles.
- beq twice, zero=1 then zero=0 → PCWrite=1 with PCSrc=01, then PCWrite=0; both take 3 cycles; InstrCount increments by 2.
- Opcode=111111 → IllegalOp pulses in DECODE; back to FETCH; InstrCount unchanged.
- Reset asserted during MEM of an sw → MemWrite drops asynchronously; State=0; InstrCount=0.
